// File: rtl/pll_seq_pkg.sv
// Shared types and 27 MHz derived defaults for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [3:0] {
    ST_PLLRST = 4'b0001,
    ST_WAIT   = 4'b0010,
    ST_STABLE = 4'b0100,
    ST_RUN    = 4'b1000
  } state_e;

  // Bit positions of the one-hot encoding, so outputs can tap state flops directly.
  localparam int IDX_PLLRST = 0;
  localparam int IDX_RUN    = 3;

  localparam int REF_CLK_HZ              = 27_000_000;
  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = REF_CLK_HZ / 1_000;    // 1 ms
  localparam int DEF_LOCK_STABLE_CYCLES  = REF_CLK_HZ / 100_000;  // 10 us

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// PLL-facing and system-facing status signals of the lock sequencer.
interface pll_lock_sequencer_if #(
  parameter int RETRY_W = 4
);
  logic               pll_lock_async;
  logic               pll_reset;
  logic               sys_rst;
  logic               ready;
  logic               lock_lost;
  logic [RETRY_W-1:0] retry_count;

  modport master (
    input  pll_lock_async,
    output pll_reset, sys_rst, ready, lock_lost, retry_count
  );

  modport slave (
    output pll_lock_async,
    input  pll_reset, sys_rst, ready, lock_lost, retry_count
  );
endinterface

// File: rtl/lock_sync_chain.sv
// Generic multi-flop synchronizer for a single asynchronous status bit.
module lock_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_chain <= '0;
    else     r_chain <= {r_chain[STAGES-2:0], i_async};
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer in the reference-clock domain.
// Build option: define PLL_LOCK_TIMEOUT_EN to enable the WAIT-state lock timeout and retry.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int SYNC_STAGES         = 2,
  parameter int RETRY_W             = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pll_lock_sequencer_if.master bus
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif

  logic               w_lock_sync;
  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_retry_inc;
  logic               w_lock_lost_nxt;
  logic               r_lock_lost;
  logic [RETRY_W-1:0] r_retry;

  lock_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (bus.pll_lock_async),
    .o_sync  (w_lock_sync)
  );

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + CNT_W'(1);
    w_retry_inc     = 1'b0;
    w_lock_lost_nxt = 1'b0;

    case (r_state)
      ST_PLLRST: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
        end
      end

      ST_WAIT: begin
        // Lock is tested first so it wins over a simultaneous timeout.
        if (w_lock_sync) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end
`ifdef PLL_LOCK_TIMEOUT_EN
        else if (r_cnt == TIMEOUT_LAST) begin
          w_state_nxt = ST_PLLRST;
          w_cnt_nxt   = '0;
          w_retry_inc = 1'b1;
        end
`else
        else begin
          w_cnt_nxt = '0;
        end
`endif
      end

      ST_STABLE: begin
        if (!w_lock_sync) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      end

      ST_RUN: begin
        w_cnt_nxt = '0;
        if (!w_lock_sync) begin
          w_state_nxt     = ST_PLLRST;
          w_retry_inc     = 1'b1;
          w_lock_lost_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_PLLRST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_PLLRST;
      r_cnt       <= '0;
      r_lock_lost <= 1'b0;
      r_retry     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_lock_lost <= w_lock_lost_nxt;
      if (w_retry_inc && (r_retry != '1))
        r_retry <= r_retry + RETRY_W'(1);
    end
  end

  // Outputs come straight from flops so downstream reset nets never see glitches.
  assign bus.pll_reset   = r_state[IDX_PLLRST];
  assign bus.sys_rst     = ~r_state[IDX_RUN];
  assign bus.ready       = r_state[IDX_RUN];
  assign bus.lock_lost   = r_lock_lost;
  assign bus.retry_count = r_retry;

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Drives the PLL `RESET` input and consumes the PLL `lock` output.
- Runs in the 27 MHz reference-clock domain, which is the same clock as the PLL `clkin`, so it keeps running even when the PLL output is dead.
- Pulses the PLL reset, waits for `lock`, filters it for stability and only then releases the system reset.
- On loss of lock it re-asserts the system reset and restarts the PLL.

Parameters:
- RST_PULSE_CYCLES, 16: number of cycles `pll_reset` is held high per attempt (minimum 1).
- LOCK_TIMEOUT_CYCLES, 27000: cycles allowed in WAIT for lock before a retry (1 ms at 27 MHz).
- LOCK_STABLE_CYCLES, 270: consecutive synced-lock cycles required before RUN (10 us).
- SYNC_STAGES, 2: depth of the lock synchronizer flop chain (minimum 2).
- RETRY_W, 4: width of the retry counter.

Ports:
- clk, input, 1: 27 MHz reference clock.
- rst, input, 1: reset.
- pll_lock_async, input, 1: raw PLL lock, asynchronous to `clk`.
- pll_reset, output, 1: drives PLL `RESET`, active-high.
- sys_rst, output, 1: system reset, active-high. Consumers in the PLL output domain re-synchronize it.
- ready, output, 1: high only while in RUN.
- lock_lost, output, 1: one-cycle pulse when lock drops during RUN.
- retry_count, output, RETRY_W: count of timeouts plus lock losses, saturating.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (`clk`, `rst`). `rst` has priority over everything.
- Reset values:
  - state = PLLRST, all counters 0, synchronizer flops 0.
  - pll_reset = 1, sys_rst = 1, ready = 0, lock_lost = 0, retry_count = 0.
- Lock synchronizer: `lock_sync` is the output of a SYNC_STAGES flop chain on `pll_lock_async`. It is the only form of lock used internally.
- State encoding: one-hot, with outputs taken directly from state flops (glitch-free):
  - pll_reset = (state == PLLRST)
  - sys_rst = (state != RUN)
  - ready = (state == RUN)
- Single counter `cnt`, wide enough for the largest of the three cycle parameters, cleared on every state transition.
- PLLRST:
  - `cnt` increments every cycle.
  - When cnt == RST_PULSE_CYCLES-1, go to WAIT. PLLRST therefore lasts exactly RST_PULSE_CYCLES cycles.
- WAIT:
  - If lock_sync = 1, go to STABLE.
  - Otherwise `cnt` increments. When cnt == LOCK_TIMEOUT_CYCLES-1, go to PLLRST and increment retry_count (see Optional Feature).
  - If lock_sync = 1 and the timeout occur in the same cycle, lock wins.
- STABLE:
  - lock_sync = 0 → go to WAIT. The timeout restarts from 0; retry_count is not incremented.
  - lock_sync = 1 and cnt == LOCK_STABLE_CYCLES-1 → go to RUN.
  - Otherwise `cnt` increments.
  - STABLE therefore lasts exactly LOCK_STABLE_CYCLES cycles with lock held.
- RUN:
  - Stays indefinitely while lock_sync = 1.
  - On lock_sync = 0: register lock_lost = 1 for exactly one cycle (the first PLLRST cycle), increment retry_count, go to PLLRST.
  - sys_rst rises in that same first PLLRST cycle.
- retry_count saturates at 2^RETRY_W - 1 and is cleared only by `rst`.
- Latency: with lock steady from the first WAIT cycle, ready rises SYNC_STAGES + 1 + LOCK_STABLE_CYCLES cycles after WAIT entry.
- Glitch filtering: a lock glitch shorter than one clk period may be missed by the synchronizer. No requirement exists to catch it.

Optional Feature:
- Macro: PLL_LOCK_TIMEOUT_EN.
- Defined: WAIT timeout and retry are active as described above.
- Undefined:
  - WAIT waits for lock indefinitely; no timeout counter logic is generated.
  - retry_count increments only on lock loss in RUN.

Decomposition:
- Shared package `pll_seq_pkg`:
  - state enum (PLLRST, WAIT, STABLE, RUN) as a one-hot typedef;
  - localparam for default 27 MHz derived cycle counts.
- One sub-module `lock_sync_chain`: parameterized SYNC_STAGES flop chain, reset to 0, reusable for other asynchronous status inputs.

Test Plan:
- All tests use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, SYNC_STAGES=2, with the macro defined unless stated.
1. rst high 3 cycles, then low, lock held 0 → pll_reset = 1 for cycles 0–3 after release and 0 from cycle 4; sys_rst = 1 throughout; ready = 0.
2. Lock rises at WAIT cycle 0 and stays high → ready = 1 and sys_rst = 0 at WAIT-entry + 11 cycles (2 + 1 + 8); lock_lost never pulses.
3. Lock never rises → pll_reset re-pulses 4 cycles after every 32 WAIT cycles; retry_count reaches 15 and holds at 15 after the 16th timeout.
4. In STABLE, lock drops for 2 cycles at STABLE cycle 5, then returns → back to WAIT with no retry increment; ready rises 11 cycles after the return is synced; retry_count stays 0.
5. In RUN, drop lock → exactly one lock_lost pulse coincident with pll_reset = 1 and sys_rst = 1; retry_count = 1; the full sequence re-runs once lock returns.
6. Macro undefined, lock held 0 for 200 cycles → pll_reset stays 0 after the initial pulse and retry_count stays 0. Assert rst mid-STABLE → next cycle is PLLRST with all outputs at reset values.
